// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader and its receive core.
package loader_pkg;

    typedef enum logic [1:0] {
        SYNC,
        LOAD,
        EXEC
    } ld_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_e;

    // Replicated per byte to build the default all-ones sync marker at any word width.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/uart_rx_core.sv
// Oversampled UART byte receiver with a 2-flop synchroniser and framing check.
// Framing is 8N1 by default; defining UART_PARITY_EN adds an even-parity bit (8E1).
module uart_rx_core
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

`ifdef UART_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    logic             rx_prev_q, rx_prev_d;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             par_ok;

    always_comb begin
        // NOTE: every _d takes its held value first, so no path through the case infers a latch.
        rx_meta_d    = rx;
        rx_sync_d    = rx_meta_q;
        rx_prev_d    = rx_sync_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_d        = par_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        par_ok       = !PARITY_EN || !par_q;

        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        bit_d   = '0;
                        par_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    par_d   = par_q ^ rx_sync_q;
                    if (bit_q == 3'd7) begin
                        state_d = PARITY_EN ? RX_PAR : RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_PAR: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = par_q ^ rx_sync_q;
                    state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_sync_q && par_ok) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Synchroniser resets low; a falling edge is needed to start a frame, so reset never fakes one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b0;
            rx_sync_q    <= 1'b0;
            rx_prev_q    <= 1'b0;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            // NOTE: registers update with non-blocking assignments so every flop sees pre-edge values.
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_program_loader.sv
// Loads a big-endian program image from UART into instruction memory, then releases the core.
// Framing follows uart_rx_core (UART_PARITY_EN selects 8E1 instead of 8N1).
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int unsigned                CLKS_PER_BIT = 16,
    parameter int unsigned                WORD_BYTES   = 4,
    parameter int unsigned                ADDR_W       = 15,
    parameter logic [8*WORD_BYTES-1:0]    SYNC_WORD    = {WORD_BYTES{SYNC_BYTE_DEFAULT}}
) (
    input  logic                      CLK,
    input  logic                      INITIALIZE,
    input  logic                      UART_RX,
    input  logic                      START_EXEC,
    output logic                      IMEM_WE,
    output logic [ADDR_W-1:0]         IMEM_ADDR,
    output logic [8*WORD_BYTES-1:0]   IMEM_WDATA,
    output logic                      LOADING,
    output logic                      RUN,
    output logic [ADDR_W:0]           WORD_COUNT,
    output logic                      ERR_FRAME,
    output logic                      ERR_OVF
);

    localparam int unsigned       WORD_W    = 8 * WORD_BYTES;
    localparam int unsigned       BCNT_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (CLK),
        .rst       (INITIALIZE),
        .rx        (UART_RX),
        .byte_valid(rx_valid),
        .byte_data (rx_byte),
        .frame_err (rx_ferr)
    );

    ld_state_e         state_q, state_d;
    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              loading_q, loading_d;
    logic              run_q, run_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_frame_q, err_frame_d;
    logic              err_ovf_q, err_ovf_d;
    logic              start_pend_q, start_pend_d;

    logic              word_done;
    logic [WORD_W-1:0] word_next;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        loading_d    = loading_q;
        run_d        = run_q;
        count_d      = count_q;
        err_frame_d  = err_frame_q;
        err_ovf_d    = err_ovf_q;
        start_pend_d = start_pend_q;
        word_done    = 1'b0;
        word_next    = WORD_W'({word_q, rx_byte});

        // Earlier bytes shift toward the MSBs, giving big-endian words.
        if (rx_valid && state_q != EXEC) begin
            word_d = word_next;
            if (byte_cnt_q == BCNT_LAST) begin
                byte_cnt_d = '0;
                word_done  = 1'b1;
            end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
        end

        if (rx_ferr && state_q != EXEC) begin
            err_frame_d = 1'b1;
        end

        // Address and count advance after the strobe; the address parks on the last slot.
        if (we_q) begin
            count_d = count_q + 1'b1;
            if (count_q + 1'b1 != DEPTH) begin
                addr_d = addr_q + 1'b1;
            end
        end

        case (state_q)
            SYNC: begin
                if (word_done && word_next == SYNC_WORD) begin
                    state_d   = LOAD;
                    loading_d = 1'b1;
                    addr_d    = '0;
                end
            end
            LOAD: begin
                if (word_done) begin
                    if (count_q == DEPTH) begin
                        err_ovf_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = word_next;
                    end
                end
                // A word finishing alongside the start request is written before EXEC begins.
                if (START_EXEC || start_pend_q) begin
                    if (word_done) begin
                        start_pend_d = 1'b1;
                    end else begin
                        state_d      = EXEC;
                        loading_d    = 1'b0;
                        run_d        = 1'b1;
                        start_pend_d = 1'b0;
                        byte_cnt_d   = '0;
                        word_d       = '0;
                    end
                end
            end
            EXEC: begin
                run_d = 1'b1;
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            state_q      <= SYNC;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            loading_q    <= 1'b0;
            run_q        <= 1'b0;
            count_q      <= '0;
            err_frame_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            loading_q    <= loading_d;
            run_q        <= run_d;
            count_q      <= count_d;
            err_frame_q  <= err_frame_d;
            err_ovf_q    <= err_ovf_d;
            start_pend_q <= start_pend_d;
        end
    end

    assign IMEM_WE    = we_q;
    assign IMEM_ADDR  = addr_q;
    assign IMEM_WDATA = wdata_q;
    assign LOADING    = loading_q;
    assign RUN        = run_q;
    assign WORD_COUNT = count_q;
    assign ERR_FRAME  = err_frame_q;
    assign ERR_OVF    = err_ovf_q;

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Receives a program image over UART, assembles big-endian words, and writes them sequentially into instruction memory.
- Once START_EXEC is seen, it releases the core with RUN.
- Successor to the fixed 8N1, 4-byte, hard-wired load path. Generalised in bit period, word width and address depth, with a sync word, error flags and an optional parity mode.
- Sits between the board UART pin and the CPU instruction-memory write port.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be at least 4.
- WORD_BYTES, 4, bytes per instruction word; word width is 8*WORD_BYTES.
- ADDR_W, 15, instruction-memory address width; depth is 2**ADDR_W.
- SYNC_WORD, all ones, marker word that must precede the program.

Ports:
- CLK  in  1  system clock
- INITIALIZE  in  1  reset, synchronous, active-high
- UART_RX  in  1  asynchronous serial input, idles high
- START_EXEC  in  1  level/pulse request to begin execution
- IMEM_WE  out  1  one-cycle instruction-memory write strobe
- IMEM_ADDR  out  ADDR_W  write address
- IMEM_WDATA  out  8*WORD_BYTES  write data
- LOADING  out  1  high while in LOAD state
- RUN  out  1  high from start of execution until reset
- WORD_COUNT  out  ADDR_W+1  number of words written
- ERR_FRAME  out  1  sticky framing/parity error
- ERR_OVF  out  1  sticky overflow error

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - INITIALIZE high at a CLK edge clears every register.
  - All outputs reset to 0; the FSM goes to SYNC.
  - Reset mid-byte abandons the partial byte and partial word.
- RX path: 2-flop synchroniser on UART_RX.
  - A falling edge in RX_IDLE starts a frame; wait CLKS_PER_BIT/2 cycles and resample.
  - If the resample is high, treat it as a glitch and return to RX_IDLE with no byte.
  - Otherwise sample 8 data bits LSB-first, one every CLKS_PER_BIT cycles, then sample the stop bit.
  - At the stop-bit sample, emit byte_valid for one cycle.
  - A stop bit of 0 sets ERR_FRAME and the byte is discarded (no byte_valid).
  - After the stop sample, RX returns to RX_IDLE immediately; back-to-back frames are accepted.
- Word assembly: the first byte of a word lands in the MSBs.
  - A byte counter 0..WORD_BYTES-1 wraps when a word completes.
  - A discarded (errored) byte does not advance the counter.
- FSM, three states:
  - SYNC: each completed word is compared to SYNC_WORD. On match go to LOAD, set LOADING=1 and address=0. A non-match is dropped and the FSM stays in SYNC.
  - LOAD: each completed word produces IMEM_WE=1 for exactly one cycle, the cycle after the final byte_valid. IMEM_ADDR and IMEM_WDATA are stable in that cycle; the address then increments and WORD_COUNT increments.
  - LOAD, overflow: a word completing when WORD_COUNT == 2**ADDR_W sets ERR_OVF, is not written, and the address does not wrap.
  - LOAD, start: START_EXEC sampled high moves the FSM to EXEC with LOADING=0 and RUN=1 on the next cycle.
  - LOAD, partial word: if START_EXEC arrives mid-word, the partial word is discarded.
  - LOAD, simultaneous events: if word completion and START_EXEC occur in the same cycle, the word is written first, then EXEC is entered.
  - EXEC: RUN is held high. UART input is ignored and no further IMEM_WE is issued. Only INITIALIZE leaves EXEC.
  - START_EXEC in SYNC is ignored.
- Widths: WORD_COUNT saturates at 2**ADDR_W. Error flags are cleared only by reset.

Optional Feature:
- UART_PARITY_EN defined: the frame is start, 8 data bits, even parity, stop (11 bits). A parity mismatch sets ERR_FRAME and discards the byte, exactly as a bad stop bit does.
- UART_PARITY_EN undefined: 8N1 framing with 10 bits and no parity bit.

Decomposition:
- Shared package loader_pkg: state enum (SYNC, LOAD, EXEC), RX state enum (RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP), and the default SYNC_WORD constant.
- One sub-module, uart_rx_core, parametrised by CLKS_PER_BIT.
  - It holds the synchroniser, bit timer and the byte_valid/frame_err outputs.
  - It is reused later by the debug console.
- uart_program_loader holds word assembly and the FSM.

Test Plan:
- Sync and load: send FFFFFFFF, 4F84E200, 4C000000, C8000000 → three IMEM_WE pulses at addresses 0, 1, 2 with those data words; WORD_COUNT=3; LOADING=1; RUN=0.
- Sync hunting: send 12345678 then FFFFFFFF then 00000001 → the first word is never written; 00000001 is written at address 0.
- Framing error: in LOAD, send a byte with its stop bit forced to 0 → ERR_FRAME=1, no byte consumed; the next 4 good bytes form word 0.
- Start glitch: drive UART_RX low for CLKS_PER_BIT/4 cycles → no byte_valid and no state change.
- Start and overflow: with ADDR_W=2, load 5 words → ERR_OVF=1 and only 4 writes. Then pulse START_EXEC for 2 cycles → RUN=1 on the next cycle, and later UART bytes produce no IMEM_WE. Then assert INITIALIZE mid-frame → all outputs 0 and state SYNC.
- Parity (UART_PARITY_EN defined): byte A5 sent with parity bit 1 → ERR_FRAME=1 and the byte is discarded; sent with parity 0 → accepted.
